// File: rtl/pkt_mem_pkg.sv
// Shared definitions for the packet-memory copy path (RX copy stage and TX serialiser):
// FSM encoding, GMII framing constants, CRC-32 constants and default widths.
package pkt_mem_pkg;

    localparam int DEF_MEM_WIDTH = 11;
    localparam int DEF_LEN_WIDTH = 11;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;

    localparam logic [31:0] CRC32_POLY    = 32'h04C11DB7;
    localparam logic [31:0] CRC32_INIT    = 32'hFFFFFFFF;
    // Remainder seen by a receiver that runs the CRC across payload plus FCS.
    localparam logic [31:0] CRC32_RESIDUE = 32'hDEBB20E3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_SFD,
        ST_PAYLOAD,
        ST_FCS,
        ST_IFG
    } tx_state_e;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/packet_mem_to_tx_crc32_byte.sv
// Combinational byte-wise CRC-32 update (reflected Ethernet form); no init or final
// inversion here, the caller owns both.
module crc32_byte
    import pkt_mem_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [7:0]  data_in,
    output logic [31:0] crc_out
);

    localparam logic [31:0] POLY_REFL = reflect32(CRC32_POLY);

    logic [31:0] c;

    always_comb begin
        c = crc_in ^ {24'h0, data_in};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ POLY_REFL) : (c >> 1);
        end
        crc_out = c;
    end

endmodule

// File: rtl/packet_mem_to_tx.sv
// Pops stored packets from packet memory and serialises them as GMII frames.
// Define PKT_TX_FCS_EN to append a CRC-32 FCS after the payload.
//
// state    | meaning
// IDLE     | waiting for a complete packet; zero-length packets are popped here
// PREAMBLE | pPREAMBLE_LEN bytes of 0x55
// SFD      | 0xD5, first payload byte fetched
// PAYLOAD  | one byte per clock from memory, next byte fetched alongside
// FCS      | four CRC bytes, LSB first (PKT_TX_FCS_EN only)
// IFG      | pIFG idle clocks
module packet_mem_to_tx
    import pkt_mem_pkg::*;
#(
    parameter int pMEM_WIDTH    = DEF_MEM_WIDTH,
    parameter int pLEN_WIDTH    = DEF_LEN_WIDTH,
    parameter int pIFG          = 12,
    parameter int pPREAMBLE_LEN = 7
)(
    input  logic                  iclk,
    input  logic                  i_rst,
    input  logic                  iempty,
    input  logic [pLEN_WIDTH-1:0] ilen_pac,
    input  logic [7:0]            ir_data,
    output logic [pMEM_WIDTH-1:0] or_addr,
    output logic                  ord_en,
    output logic                  opkt_pop,
    output logic                  otx_en,
    output logic [7:0]            otx_d,
    output logic                  otx_er,
    output logic                  obusy
);

    localparam int TMR_MAX_A = (pIFG > pPREAMBLE_LEN) ? pIFG : pPREAMBLE_LEN;
    localparam int TMR_MAX   = (TMR_MAX_A > 4) ? TMR_MAX_A : 4;
    localparam int TMR_W     = $clog2(TMR_MAX + 1);

    tx_state_e             state_q, state_d;
    logic [TMR_W-1:0]      timer_q, timer_d;
    logic [pLEN_WIDTH-1:0] cnt_q, cnt_d;
    logic [pLEN_WIDTH-1:0] len_q, len_d;
    logic [pMEM_WIDTH-1:0] rd_ptr_q, rd_ptr_d;

`ifdef PKT_TX_FCS_EN
    // Accumulates over payload, then holds the inverted FCS and shifts it out.
    logic [31:0] crc_q, crc_d, crc_nxt;

    crc32_byte u_crc32_byte (
        .crc_in  (crc_q),
        .data_in (ir_data),
        .crc_out (crc_nxt)
    );
`endif

    always_ff @(posedge iclk or negedge i_rst) begin
        if (!i_rst) begin
            state_q  <= ST_IDLE;
            timer_q  <= '0;
            cnt_q    <= '0;
            len_q    <= '0;
            rd_ptr_q <= '0;
`ifdef PKT_TX_FCS_EN
            crc_q    <= CRC32_INIT;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            cnt_q    <= cnt_d;
            len_q    <= len_d;
            rd_ptr_q <= rd_ptr_d;
`ifdef PKT_TX_FCS_EN
            crc_q    <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        cnt_d    = cnt_q;
        len_d    = len_q;
        rd_ptr_d = rd_ptr_q;
`ifdef PKT_TX_FCS_EN
        crc_d    = crc_q;
`endif
        ord_en   = 1'b0;
        or_addr  = '0;
        opkt_pop = 1'b0;
        otx_en   = 1'b0;
        otx_d    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (!iempty) begin
                    if (ilen_pac == '0) begin
                        // Reset parks the FSM here; keep the pop quiet until released.
                        opkt_pop = i_rst;
                    end else begin
                        len_d   = ilen_pac;
                        timer_d = TMR_W'(pPREAMBLE_LEN - 1);
                        state_d = ST_PREAMBLE;
                    end
                end
            end

            ST_PREAMBLE: begin
                otx_en = 1'b1;
                otx_d  = PREAMBLE_BYTE;
                if (timer_q == '0) begin
                    state_d = ST_SFD;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            ST_SFD: begin
                otx_en  = 1'b1;
                otx_d   = SFD_BYTE;
                ord_en  = 1'b1;
                or_addr = rd_ptr_q;
                cnt_d   = '0;
                state_d = ST_PAYLOAD;
`ifdef PKT_TX_FCS_EN
                crc_d   = CRC32_INIT;
`endif
            end

            ST_PAYLOAD: begin
                otx_en = 1'b1;
                otx_d  = ir_data;
`ifdef PKT_TX_FCS_EN
                crc_d  = crc_nxt;
`endif
                if (cnt_q != len_q - pLEN_WIDTH'(1)) begin
                    ord_en  = 1'b1;
                    or_addr = rd_ptr_q + pMEM_WIDTH'(cnt_q) + pMEM_WIDTH'(1);
                    cnt_d   = cnt_q + pLEN_WIDTH'(1);
                end else begin
                    rd_ptr_d = rd_ptr_q + pMEM_WIDTH'(len_q);
                    opkt_pop = 1'b1;
`ifdef PKT_TX_FCS_EN
                    crc_d    = ~crc_nxt;
                    timer_d  = TMR_W'(3);
                    state_d  = ST_FCS;
`else
                    timer_d  = TMR_W'(pIFG - 1);
                    state_d  = ST_IFG;
`endif
                end
            end

`ifdef PKT_TX_FCS_EN
            ST_FCS: begin
                otx_en = 1'b1;
                otx_d  = crc_q[7:0];
                crc_d  = {8'h00, crc_q[31:8]};
                if (timer_q == '0) begin
                    timer_d = TMR_W'(pIFG - 1);
                    state_d = ST_IFG;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end
`endif

            ST_IFG: begin
                if (timer_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    timer_d = timer_q - TMR_W'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign otx_er = 1'b0;
    assign obusy  = (state_q != ST_IDLE);

endmodule
